// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg : shared types and phase-step constants for the audio resampler
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    RATE_44K  = 2'd0,
    RATE_37K8 = 2'd1,
    RATE_18K9 = 2'd2
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_MULT    = 2'd2,
    ST_SUM     = 2'd3
  } state_e;

  // Phase increment per 44.1 kHz output tick, as a 1.16 fixed-point ratio.
  localparam logic [16:0] STEP_44K  = 17'd65536;
  localparam logic [16:0] STEP_37K8 = 17'd56174;
  localparam logic [16:0] STEP_18K9 = 17'd28087;

  // The reserved encoding falls back to passthrough.
  function automatic logic [16:0] step_for(input logic [1:0] rate);
    logic [16:0] step;
    case (rate)
      2'd1:    step = STEP_37K8;
      2'd2:    step = STEP_18K9;
      default: step = STEP_44K;
    endcase
    return step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_lerp.sv
// ---------------------------------------------------------------------------
// audio_lerp : one channel of the interpolator (s0/s1 history, multiply, add)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_lerp
  import audio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift_i,
  input  logic        load_i,
  input  logic        mult_i,
  input  logic [15:0] sample_i,
  input  logic [15:0] frac_i,
  output logic [15:0] y_o
);

  sample_t            s0_q;
  sample_t            s1_q;
  logic signed [33:0] prod_q;
  logic signed [16:0] diff;

  assign diff = {s1_q[15], s1_q} - {s0_q[15], s0_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_q   <= '0;
      s1_q   <= '0;
      prod_q <= '0;
    end else begin
      if (shift_i) s0_q <= s1_q;
      if (load_i)  s1_q <= sample_i;
      if (mult_i)  prod_q <= 34'(diff) * $signed({18'd0, frac_i});
    end
  end

  // Floor of prod/65536 keeps the result inside [s0, s1], so no clamp is needed.
  assign y_o = s0_q + 16'(prod_q >>> 16);

endmodule

`default_nettype wire

// File: rtl/audio_resampler.sv
// ---------------------------------------------------------------------------
// audio_resampler : stereo linear-interpolating SRC, FIFO pop side to 44.1 kHz
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_resampler
  import audio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rate_i,
  input  logic        mono_i,
  input  logic        out_tick_i,
  input  logic [15:0] in_left_sample_i,
  input  logic        in_left_write_i,
  output logic        in_left_strobe_o,
  input  logic [15:0] in_right_sample_i,
  input  logic        in_right_write_i,
  output logic        in_right_strobe_o,
  output logic [15:0] out_left_o,
  output logic [15:0] out_right_o,
  output logic        out_valid_o,
  output logic        underrun_o,
  output logic        tick_dropped_o
);

  state_e      state_q;
  logic [15:0] frac_q;
  logic [15:0] out_left_q;
  logic [15:0] out_right_q;
  logic        out_valid_q;

  logic [16:0] phase_d;
  logic        carry;
  logic        ready;
  logic        advance;
  logic        pop;
  logic [15:0] y_left;
  logic [15:0] y_right;

  assign phase_d = {1'b0, frac_q} + step_for(rate_i);
  assign carry   = phase_d[16];
  assign ready   = in_left_write_i & (mono_i | in_right_write_i);
  assign advance = (state_q == ST_ADVANCE);
  assign pop     = advance & carry & ready;

  // Both channels pop together or not at all, so they never drift apart.
  assign in_left_strobe_o  = pop;
  assign in_right_strobe_o = pop & ~mono_i;
  assign underrun_o        = advance & carry & ~ready;
  assign tick_dropped_o    = out_tick_i & (state_q != ST_IDLE);

  audio_lerp u_lerp_left (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_i  (advance & carry),
    .load_i   (in_left_strobe_o),
    .mult_i   (state_q == ST_MULT),
    .sample_i (in_left_sample_i),
    .frac_i   (frac_q),
    .y_o      (y_left)
  );

  audio_lerp u_lerp_right (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_i  (advance & carry),
    .load_i   (in_right_strobe_o),
    .mult_i   (state_q == ST_MULT),
    .sample_i (in_right_sample_i),
    .frac_i   (frac_q),
    .y_o      (y_right)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      frac_q      <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (out_tick_i) state_q <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          frac_q  <= phase_d[15:0];
          state_q <= ST_MULT;
        end
        ST_MULT: begin
          state_q <= ST_SUM;
        end
        ST_SUM: begin
          out_left_q  <= y_left;
          out_right_q <= mono_i ? y_left : y_right;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_left_o  = out_left_q;
  assign out_right_o = out_right_q;
  assign out_valid_o = out_valid_q;

endmodule

`default_nettype wire

// File: doc/audio_resampler.md
# audio_resampler

Stereo linear-interpolating sample-rate converter downstream of the per-channel audio FIFOs. It pops 16-bit signed samples at the source rate (44.1, 37.8 or 18.9 kHz), driven by a 16-bit fractional phase accumulator. On each output tick it emits one interpolated stereo pair at 44.1 kHz to the DAC/mixer stage.

## Interface
- No parameters; step constants come from the shared package.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rate  in  2  source rate: 0 = 44.1k, 1 = 37.8k, 2 = 18.9k, 3 = reserved (treated as 0)
- mono  in  1  pop left FIFO only; right output copies left
- out_tick  in  1  one-cycle pulse at 44.1 kHz from the clock divider
- in_left  audiostream.sink  (sample 16 signed, write = data available, strobe = pop, driven by this block)
- in_right  audiostream.sink  same, right channel
- out_left, out_right  out  16  signed interpolated samples, registered
- out_valid  out  1  one-cycle pulse when outputs update
- underrun  out  1  one-cycle pulse when a required pop was not possible
- tick_dropped  out  1  one-cycle pulse when out_tick arrives while busy

## Operation
- State per channel: s0 (previous sample) and s1 (next sample), each 16-bit signed. Shared frac is 16-bit unsigned.
- Step: 65536 (rate 0/3), 56174 (rate 1), 28087 (rate 2). The step is sampled in ADVANCE, so a rate change takes effect on the next tick and frac is not cleared.
- FSM states: IDLE, ADVANCE, MULT, SUM.
- IDLE: out_tick=1 moves to ADVANCE. Otherwise stay.
- ADVANCE: sum = frac + step (17 bits). frac <= sum[15:0]. carry = sum[16]. Always go to MULT.
  - carry=1 and data ready (in_left.write, plus in_right.write when mono=0): s0 <= s1. s1 <= in.sample, captured in the same cycle strobe is asserted. Strobe both channels, or left only when mono.
  - carry=1 and data not ready: s0 <= s1, s1 unchanged (holds the last sample). No strobe on any channel, even one that has data, so the channels stay aligned. underrun pulses.
  - carry=0: no pop, no strobe.
- MULT: diff = s1 − s0 (17-bit signed). prod = diff × {0,frac} (34-bit signed), registered.
- SUM: y = s0 + (prod >>> 16), arithmetic shift (floor). Register the low 16 bits to out_*, pulse out_valid, return to IDLE.
  - The result always lies within [s0, s1], so no saturation is needed. The bench asserts this.
- When mono=1, the right datapath takes the left values: out_right equals out_left.
- strobe is combinational and high only in ADVANCE under the pop condition. It never asserts when the FIFO's write is low.
- out_tick outside IDLE: tick_dropped pulses and the tick is ignored, with no phase advance.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; s0, s1, frac = 0; out_left, out_right = 0; out_valid, underrun, tick_dropped = 0; strobes low.
- out_tick high in cycle T gives:
  - ADVANCE in cycle T+1 (strobe and underrun, if any, occur here);
  - MULT in T+2;
  - SUM in T+3;
  - out_valid high in T+4 only, with out_* stable from T+4 until the next update.
- Latency is fixed at 4 cycles, independent of carry. Minimum tick spacing is 4 cycles: a tick in T+1..T+3 is dropped, a tick in T+4 is accepted.
- At most one pop per channel per tick, because step ≤ 65536.
- reset_n asserted mid-operation aborts immediately. No strobe or out_valid is issued after release until a new tick.
- Passthrough (step 65536): frac stays 0 and output = s0, i.e. one output-sample delay.

## Structure
- audio_pkg holds the rate enum (RATE_44K, RATE_37K8, RATE_18K9), the step constants, and the sample_t (signed 16) typedef.
- Sub-module audio_lerp holds one channel's datapath: s0/s1 registers, shift/load, diff, multiply, add. It is instantiated twice and the FSM stays in audio_resampler.

## Test plan
- Passthrough: rate=0, left FIFO 100, 200, 300, right −100, −200, −300, 3 ticks → outputs (0,0), (100,−100), (200,−200). One strobe per channel per tick, out_valid 4 cycles after each tick.
- 18.9 kHz DC: rate=2, mono=1, left FIFO holds 8000s → outputs 0, 0, 2285 on ticks 1-3. The first pop occurs on tick 3 (frac=18725), with no right strobe.
- Underrun: rate=0, left has data, right FIFO empty, stereo → no strobes, underrun pulse at T+1, output repeats the previous s1, and the left FIFO count is unchanged.
- Tick overrun: ticks at cycles 0 and 2 → tick_dropped at cycle 2, a single out_valid at cycle 4, frac advanced once. A tick at cycle 4 is accepted.
- Rate switch: change rate from 1 to 2 between ticks → frac continues from its prior value with step 28087 applied from the next ADVANCE.
- Reset mid-op: drop reset_n during MULT → all outputs 0 immediately, no out_valid after release, and the next tick interpolates from s0=s1=0.
